// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding, SDA drive levels and word width for the I2C receive slave
package i2c_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE} state_t;
  localparam logic ACK_LVL  = 1'b1;
  localparam logic NACK_LVL = 1'b0;
  localparam int   WORD_W   = 32;
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: synchronizes SCL/SDA into clk and detects SCL edges plus START/STOP
//   clk, rst            : clock, async active-high reset (flops preset to idle bus = 1)
//   scl_in, sda_in      : raw bus lines
//   sda                 : synchronized SDA level
//   scl_rise, scl_fall  : one-cycle synchronized SCL edge strobes
//   start, stop         : one-cycle bus condition strobes
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);
  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic r_scl_prev, r_sda_prev;
  logic w_scl;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
      r_scl_prev <= w_scl;
      r_sda_prev <= sda;
    end
  end
  assign w_scl    = r_scl_sync[SYNC_STAGES-1];
  assign sda      = r_sda_sync[SYNC_STAGES-1];
  assign scl_rise = w_scl & ~r_scl_prev;
  assign scl_fall = ~w_scl & r_scl_prev;
  // SCL must be high on both samples so an SDA move coincident with an SCL edge is not a bus condition
  assign start    = w_scl & r_scl_prev & r_sda_prev & ~sda;
  assign stop     = w_scl & r_scl_prev & ~r_sda_prev & sda;
endmodule

// File: rtl/slave_rx.sv
// slave_rx: write-only I2C slave packing received bytes into 32-bit words through a two-entry ping-pong buffer
//   clk, rst           : clock, async active-high reset
//   scl_in, sda_in     : raw I2C lines
//   sda_oe             : 1 pulls SDA low (ACK)
//   rx_data, rx_valid  : oldest completed word and its valid flag
//   rx_ready           : consumer pop
//   RXBuff0, RXBuff1   : buffer full flags
//   overflow           : sticky, a word was refused for lack of space
//   busy               : addressed transaction in progress
module slave_rx
  import i2c_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] OWN_ADDR    = 7'h2A
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              RXBuff0,
  output logic              RXBuff1,
  output logic              overflow,
  output logic              busy
);
  state_t r_state, w_state_nx;
  logic r_oe, w_oe_nx, r_ph, w_ph_nx;
  logic [2:0] r_bit_cnt;
  logic [1:0] r_byte_cnt;
  logic [7:0] r_shift;
  logic [WORD_W-9:0] r_word;
  logic [WORD_W-1:0] r_buf [2];
  logic [1:0] r_full;
  logic r_wr_sel, r_rd_sel, r_ovf;
  logic w_sda, w_rise, w_fall, w_start, w_stop;
  logic w_last, w_push, w_drop, w_pop;
  logic [7:0] w_byte;
  logic [WORD_W-1:0] w_word;
  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in),
    .sda(w_sda), .scl_rise(w_rise), .scl_fall(w_fall), .start(w_start), .stop(w_stop)
  );
  assign w_byte = {r_shift[6:0], w_sda};
  assign w_word = {r_word, w_byte};
  assign w_last = w_rise & (r_bit_cnt == 3'd7);
  assign w_pop  = rx_valid & rx_ready;
  always_comb begin
    w_state_nx = r_state;
    w_oe_nx    = r_oe;
    w_ph_nx    = r_ph;
    w_push     = 1'b0;
    w_drop     = 1'b0;
    if (w_start || w_stop) begin
      w_state_nx = w_start ? ADDR : IDLE;
      w_oe_nx    = NACK_LVL;
      w_ph_nx    = 1'b0;
    end else begin
      case (r_state)
        ADDR: if (w_last) w_state_nx = (w_byte[7:1] == OWN_ADDR && !w_byte[0]) ? ADDR_ACK : IGNORE;
        DATA: if (w_last) begin
          // space is judged on the flags before this cycle's pop
          w_drop     = (r_byte_cnt == 2'd3) & (&r_full);
          w_push     = (r_byte_cnt == 2'd3) & ~(&r_full);
          w_state_nx = w_drop ? IGNORE : DATA_ACK;
        end
        // first SCL fall drives the ACK, second releases it; both happen with SCL low
        ADDR_ACK, DATA_ACK: if (w_fall) begin
          w_oe_nx    = r_ph ? NACK_LVL : ACK_LVL;
          w_ph_nx    = ~r_ph;
          w_state_nx = r_ph ? DATA : r_state;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_oe    <= NACK_LVL;
      r_ph    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_oe    <= w_oe_nx;
      r_ph    <= w_ph_nx;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
      r_shift    <= '0;
      r_word     <= '0;
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
      r_full     <= '0;
      r_wr_sel   <= 1'b0;
      r_rd_sel   <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_start) begin
        r_bit_cnt  <= '0;
        r_byte_cnt <= '0;
      end else if (w_rise && (r_state == ADDR || r_state == DATA)) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
        r_shift   <= w_byte;
      end
      if (!w_start && r_state == DATA && w_last) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        r_word     <= w_word[WORD_W-9:0];
      end
      // push targets the free buffer and pop the full one, so they never collide
      if (w_push) begin
        r_buf[r_wr_sel]  <= w_word;
        r_full[r_wr_sel] <= 1'b1;
        r_wr_sel         <= ~r_wr_sel;
      end
      if (w_pop) begin
        r_full[r_rd_sel] <= 1'b0;
        r_rd_sel         <= ~r_rd_sel;
      end
      if (w_drop) r_ovf <= 1'b1;
    end
  end
  assign sda_oe   = r_oe;
  assign rx_data  = r_buf[r_rd_sel];
  assign rx_valid = r_full[r_rd_sel];
  assign RXBuff0  = r_full[0];
  assign RXBuff1  = r_full[1];
  assign overflow = r_ovf;
  assign busy     = !(r_state == IDLE || r_state == IGNORE);
endmodule

// File: tb/tb_slave_rx.sv
// tb_slave_rx: drives I2C write transactions and checks ACKs and delivered words against a word-queue model
module tb_slave_rx;
  localparam logic [6:0] OWN = 7'h2A;
  localparam int SYNC = 2;
  localparam int Q = 6;
  logic clk = 0, rst = 1, scl_in = 1, m_sda = 1, rx_ready = 0;
  logic sda_in, sda_oe, rx_valid, RXBuff0, RXBuff1, overflow, busy;
  logic [31:0] rx_data;
  int total = 0, bad = 0;
  logic [31:0] mq [$];
  bit m_ovf = 0;
  logic [31:0] popped;
  logic [7:0] txd [16];
  int oe_glitch = 0, oe_cnt = 0;
  logic prev_scl = 1, prev_oe = 0;
  assign sda_in = m_sda & ~sda_oe;
  always #5 clk = ~clk;
  slave_rx #(.SYNC_STAGES(SYNC), .OWN_ADDR(OWN)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .RXBuff0(RXBuff0), .RXBuff1(RXBuff1), .overflow(overflow), .busy(busy)
  );
  always @(posedge clk) begin
    if (!rst && scl_in && prev_scl && sda_oe !== prev_oe) oe_glitch++;
    if (sda_oe) oe_cnt++;
    prev_scl = scl_in;
    prev_oe = sda_oe;
  end
  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bit_out(input logic b, input bit pop);
    m_sda = b;
    wait_q();
    scl_in = 1;
    if (pop) begin
      repeat (SYNC) @(negedge clk);
      popped = rx_data;
      rx_ready = 1;
      @(negedge clk);
      rx_ready = 0;
      repeat (Q - SYNC - 1) @(negedge clk);
    end else wait_q();
    scl_in = 0;
    wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit pop, output logic ack);
    for (int i = 7; i >= 0; i--) bit_out(b[i], pop && i == 0);
    m_sda = 1;
    wait_q();
    scl_in = 1;
    wait_q();
    ack = sda_oe;
    scl_in = 0;
    wait_q();
  endtask

  task automatic i2c_start();
    m_sda = 1;
    wait_q();
    scl_in = 1;
    wait_q();
    m_sda = 0;
    wait_q();
    scl_in = 0;
    wait_q();
  endtask

  task automatic i2c_stop();
    m_sda = 0;
    wait_q();
    scl_in = 1;
    wait_q();
    m_sda = 1;
    wait_q();
  endtask

  task automatic send_txn(input logic [7:0] a, input int n, input bit stop, input bit pop_last);
    logic ack;
    bit active, exp;
    logic [31:0] w = 0, d;
    i2c_start();
    send_byte(a, 0, ack);
    active = (a == {OWN, 1'b0});
    total++;
    if (ack !== active) begin bad++; $display("FAIL addr_ack a=%h got=%b exp=%b", a, ack, active); end
    total++;
    if (busy !== active) begin bad++; $display("FAIL busy_after_addr got=%b exp=%b", busy, active); end
    for (int i = 0; i < n; i++) begin
      exp = active && !((i % 4 == 3) && mq.size() == 2);
      send_byte(txd[i], pop_last && i == n - 1, ack);
      total++;
      if (ack !== exp) begin bad++; $display("FAIL data_ack byte=%0d got=%b exp=%b", i, ack, exp); end
      if (pop_last && i == n - 1) begin
        total++;
        if (mq.size() == 0) begin bad++; $display("FAIL same_cycle_pop got=%h exp=none", popped); end
        else begin
          d = mq.pop_front();
          if (popped !== d) begin bad++; $display("FAIL same_cycle_pop got=%h exp=%h", popped, d); end
        end
      end
      w = {w[23:0], txd[i]};
      if (active && !exp) begin
        m_ovf = 1;
        active = 0;
      end else if (exp && i % 4 == 3) mq.push_back(w);
    end
    if (stop) begin
      i2c_stop();
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL busy_after_stop got=%b exp=0", busy); end
    end
    total++;
    if (overflow !== m_ovf) begin bad++; $display("FAIL overflow got=%b exp=%b", overflow, m_ovf); end
    total++;
    if (32'(RXBuff0) + 32'(RXBuff1) != 32'(mq.size()) || rx_valid !== (mq.size() > 0)) begin
      bad++;
      $display("FAIL occupancy got=%b%b valid=%b exp_words=%0d", RXBuff1, RXBuff0, rx_valid, mq.size());
    end
  endtask

  task automatic pop_word();
    int t = 0;
    logic [31:0] e;
    while (!rx_valid && t < 20) begin @(negedge clk); t++; end
    e = mq.pop_front();
    total++;
    if (!rx_valid) begin bad++; $display("FAIL pop_timeout got=valid0 exp=%h", e); end
    else begin
      if (rx_data !== e) begin bad++; $display("FAIL pop_data got=%h exp=%h", rx_data, e); end
      rx_ready = 1;
      @(negedge clk);
      rx_ready = 0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({sda_oe, rx_valid, RXBuff0, RXBuff1, overflow, busy} !== 6'b0 || rx_data !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%b data=%h exp=0", {sda_oe, rx_valid, RXBuff0, RXBuff1, overflow, busy}, rx_data);
    end
    rst = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic();
    txd[0] = 8'hDE; txd[1] = 8'hAD; txd[2] = 8'hBE; txd[3] = 8'hEF;
    send_txn(8'h54, 4, 1, 0);
    total++;
    if (rx_data !== 32'hDEADBEEF || RXBuff0 !== 1'b1 || RXBuff1 !== 1'b0) begin
      bad++;
      $display("FAIL basic_word got=%h b0=%b b1=%b exp=deadbeef b0=1 b1=0", rx_data, RXBuff0, RXBuff1);
    end
    pop_word();
  endtask

  task automatic test_wrong_addr();
    int c0 = oe_cnt;
    for (int i = 0; i < 4; i++) txd[i] = 8'($urandom);
    send_txn(8'h56, 4, 1, 0);
    total++;
    if (oe_cnt != c0) begin bad++; $display("FAIL wrong_addr_oe got=%0d exp=0", oe_cnt - c0); end
    send_txn(8'h55, 2, 1, 0);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 12; i++) txd[i] = 8'($urandom);
    send_txn(8'h54, 12, 1, 0);
    total++;
    if (overflow !== 1'b1 || RXBuff0 !== 1'b1 || RXBuff1 !== 1'b1) begin
      bad++;
      $display("FAIL overflow_state got=%b%b%b exp=111", overflow, RXBuff1, RXBuff0);
    end
    pop_word();
    pop_word();
  endtask

  task automatic test_partial();
    txd[0] = 8'h11; txd[1] = 8'h22;
    send_txn(8'h54, 2, 1, 0);
    txd[0] = 8'h33; txd[1] = 8'h44; txd[2] = 8'h55; txd[3] = 8'h66;
    send_txn(8'h54, 4, 1, 0);
    total++;
    if (rx_data !== 32'h33445566) begin bad++; $display("FAIL partial_word got=%h exp=33445566", rx_data); end
    pop_word();
    for (int i = 0; i < 3; i++) txd[i] = 8'($urandom);
    send_txn(8'h54, 3, 0, 0);
    for (int i = 0; i < 4; i++) txd[i] = 8'($urandom);
    send_txn(8'h54, 4, 1, 0);
    pop_word();
    total++;
    if (rx_valid !== 1'b0) begin bad++; $display("FAIL partial_drain got=%b exp=0", rx_valid); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) txd[i] = 8'($urandom);
    send_txn(8'h54, 4, 1, 0);
    for (int i = 0; i < 4; i++) txd[i] = 8'($urandom);
    send_txn(8'h54, 4, 1, 1);
    total++;
    if ((RXBuff0 ^ RXBuff1) !== 1'b1 || mq.size() != 1 || rx_data !== mq[0]) begin
      bad++;
      $display("FAIL same_cycle_state got=%b%b data=%h exp_words=1", RXBuff1, RXBuff0, rx_data);
    end
  endtask

  task automatic test_rst_mid();
    logic ack;
    i2c_start();
    send_byte(8'h54, 0, ack);
    bit_out(1'b1, 0);
    bit_out(1'b0, 0);
    m_sda = 1;
    scl_in = 1;
    @(negedge clk);
    #2 rst = 1;
    #1;
    total++;
    if ({sda_oe, rx_valid, RXBuff0, RXBuff1, overflow, busy} !== 6'b0 || rx_data !== 32'h0) begin
      bad++;
      $display("FAIL rst_mid got=%b data=%h exp=0", {sda_oe, rx_valid, RXBuff0, RXBuff1, overflow, busy}, rx_data);
    end
    mq.delete();
    m_ovf = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) txd[i] = 8'($urandom);
    send_txn(8'h54, 4, 1, 0);
    pop_word();
  endtask

  task automatic test_random();
    int r, n;
    logic [7:0] a;
    bit stop;
    for (int k = 0; k < 12; k++) begin
      while (mq.size() > 0 && $urandom_range(0, 1) == 1) pop_word();
      r = $urandom_range(0, 9);
      a = r < 7 ? 8'h54 : r == 7 ? 8'h56 : r == 8 ? 8'h55 : 8'hA8;
      n = $urandom_range(0, 10);
      stop = $urandom_range(0, 3) != 0;
      for (int i = 0; i < n; i++) txd[i] = 8'($urandom);
      send_txn(a, n, stop, 0);
    end
    i2c_stop();
    while (mq.size() > 0) pop_word();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrong_addr();
    test_overflow();
    test_partial();
    test_back_to_back();
    test_rst_mid();
    test_random();
    total++;
    if (oe_glitch != 0) begin bad++; $display("FAIL oe_while_scl_high got=%0d exp=0", oe_glitch); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/slave_rx.md
SLAVE_RX -- requirements
Module: slave_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the number of flops in the SCL/SDA input synchronizers (minimum 2).
REQ-002 SHALL have parameter OWN_ADDR, default 7'h2A, the 7-bit I2C slave address this block answers.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 scl_in  input  1  raw I2C SCL line level, asynchronous to clk.
REQ-006 sda_in  input  1  raw I2C SDA line level, asynchronous to clk.
REQ-007 sda_oe  output  1  1 = pull SDA low (ACK); 0 = release; open-drain, no other SDA drive.
REQ-008 rx_data  output  32  oldest completed received word.
REQ-009 rx_valid  output  1  rx_data holds a valid word.
REQ-010 rx_ready  input  1  consumer pop; a word is consumed in any cycle with rx_valid & rx_ready.
REQ-011 RXBuff0, RXBuff1  output  1 each  full flag of each receive buffer.
REQ-012 overflow  output  1  sticky; a word was refused because both buffers were full.
REQ-013 busy  output  1  addressed transaction in progress (state not IDLE/IGNORE).

Function
REQ-014 SCL/SDA SHALL pass through SYNC_STAGES flops; edges/conditions are detected on synchronized values, one extra flop for the previous value.
REQ-015 START = synced SDA 1->0 while SCL high; STOP = synced SDA 0->1 while SCL high; both take priority over every state.
REQ-016 States: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
REQ-017 IDLE/IGNORE/any state + START -> ADDR with bit counter and byte counter cleared (repeated START included); any state + STOP -> IDLE, sda_oe=0.
REQ-018 ADDR/DATA: SDA sampled MSB first on each SCL rising edge; 3-bit bit counter; after 8th sample -> ADDR_ACK/DATA_ACK.
REQ-019 ADDR_ACK: if addr byte[7:1]==OWN_ADDR and bit0==0 (write), sda_oe SHALL assert on the next SCL falling edge and release on the following SCL falling edge, then -> DATA; otherwise sda_oe stays 0 and -> IGNORE.
REQ-020 Data bytes SHALL assemble into a 32-bit word, first byte in bits [31:24]; 2-bit byte counter wraps 3->0.
REQ-021 ACK decision for a byte SHALL be made in the cycle its 8th bit is sampled: ACK unless it is the 4th byte of a word and both buffers are full at that cycle.
REQ-022 Word-completing byte with a free buffer: word written into buffer selected by wr_sel (ping-pong, starts 0) in that same cycle; corresponding RXBuff flag and rx_valid high on the next clk edge.
REQ-023 Word-completing byte with no free buffer: word dropped, byte NACKed, overflow set, -> IGNORE.
REQ-024 rx_data SHALL show buffer rd_sel (ping-pong, starts 0); pop clears its full flag and toggles rd_sel.
REQ-025 Push and pop in the same cycle SHALL both take effect; a pop in that cycle does not free space for that cycle's ACK decision.
REQ-026 STOP or repeated START with a partial word (byte counter != 0) SHALL discard the partial word; full buffers untouched.
REQ-027 sda_oe SHALL never change while synced SCL is high.

Reset
REQ-028 rst SHALL force: state IDLE, sda_oe=0, rx_data=0, rx_valid=0, RXBuff0=RXBuff1=0, overflow=0, busy=0, wr_sel=rd_sel=0, counters=0, synchronizer flops=1 (bus idle).
REQ-029 rst mid-transfer SHALL abandon the transfer; after release the block waits for a fresh START.
REQ-030 overflow SHALL be cleared only by rst.

Structure
REQ-031 Package i2c_pkg SHALL hold the state enum, the ACK/NACK level constants and the 32-bit word-width constant.
REQ-032 Sub-module i2c_line_sync SHALL contain the synchronizers and SCL rise/fall, START, STOP detection.

Verification
REQ-033 START, 0x54 (0x2A write), 0xDE 0xAD 0xBE 0xEF, STOP -> five ACKs, rx_data=32'hDEADBEEF, rx_valid=1, RXBuff0=1.
REQ-034 Address 0x56 (0x2B write) -> no ACK, sda_oe=0 throughout, no buffer change, busy=0.
REQ-035 rx_ready=0, three words sent -> words 1,2 ACKed into RXBuff0/RXBuff1, 12th data byte NACKed, overflow=1; popping yields words 1 then 2.
REQ-036 STOP after 2 data bytes 0x11 0x22, then full word 0x33445566 -> only 32'h33445566 delivered.
REQ-037 Pop in the same cycle a word lands in the other buffer -> both flags correct, no word lost or duplicated.
REQ-038 rst asserted mid-data-byte -> all outputs at reset values immediately; next full transaction received correctly.
